// File: rtl/wave_gen_burst_sweep.sv
// -----------------------------------------------------------------------------
// wave_gen_burst_sweep
//
// Waveform source for the DSP chain. A wide fractional phase accumulator drives
// a selectable shape (sine LUT, square with 8-bit duty, triangle, sawtooth, DC).
// Gain is applied in Q1.(GAIN_W-1), then a signed offset is added and the result
// is saturated. A run-control FSM provides continuous, linear-sweep and
// burst/gap modes. One sample is produced per accepted i_sample_en strobe and
// appears on o_wave with a one-cycle o_valid pulse three cycles later.
//
// Handshake: o_valid is a single-cycle qualifier with no back-pressure; the
// consumer must take o_wave/o_clip in the cycle o_valid is high. i_sample_en
// is accepted in any active state unless i_stop is high in the same cycle.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_sample_en         sample strobe
//   i_start, i_stop     run control pulses (stop wins over start)
//   i_mode, i_loop      run mode / sweep loop, latched at start
//   i_step              phase step for continuous and burst, latched at start
//   i_f_start/inc/stop  sweep start step, increment, end step, latched at start
//   i_burst_cycles      phase wraps per burst (0 means 1), latched at start
//   i_gap_samples       muted samples between bursts, latched at start
//   i_sel_wave, i_duty  shape select and square duty, live
//   i_gain, i_offset    amplitude gain and signed offset, live
//   o_wave, o_valid     signed sample and its qualifier
//   o_clip              sample was saturated (only with o_valid)
//   o_busy              FSM not idle
//   o_done              pulse when a non-looping sweep completes
//   o_dbg_state         current FSM state encoding
// -----------------------------------------------------------------------------
module wave_gen_burst_sweep #(
    parameter int WIDTH    = 24,
    parameter int PHASE_W  = 32,
    parameter int LUT_AW   = 10,
    parameter int GAIN_W   = 8,
    parameter     HEX_LINK = "../04_fir_cof/sine_wave_0.1.txt"
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sample_en,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [1:0]         i_mode,
    input  logic               i_loop,
    input  logic [PHASE_W-1:0] i_step,
    input  logic [PHASE_W-1:0] i_f_start,
    input  logic [PHASE_W-1:0] i_f_inc,
    input  logic [PHASE_W-1:0] i_f_stop,
    input  logic [7:0]         i_burst_cycles,
    input  logic [15:0]        i_gap_samples,
    input  logic [2:0]         i_sel_wave,
    input  logic [7:0]         i_duty,
    input  logic [GAIN_W-1:0]  i_gain,
    input  logic [WIDTH-1:0]   i_offset,
    output logic [WIDTH-1:0]   o_wave,
    output logic               o_valid,
    output logic               o_clip,
    output logic               o_busy,
    output logic               o_done,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_BURST_ON  = 2'd2,
        S_BURST_OFF = 2'd3
    } state_t;

    // Product width holds shape (signed WIDTH) times {0,gain} (GAIN_W+1).
    localparam int PW = WIDTH + GAIN_W + 1;
    localparam logic signed [PW:0] SAT_MAX = {{(PW + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN = {{(PW + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0]   SQ_HIGH = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0]   SQ_LOW  = {1'b1, {(WIDTH - 2){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Sine table. Contents are generated at elaboration with Bhaskara's
    // rational sine approximation, so the block carries no file dependency;
    // HEX_LINK is kept only so existing instantiations still elaborate.
    // Entries are full-wave, peak +/-(2^(WIDTH-1)-1).
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] sine_entry(input int idx);
        longint idx_l, h, k, num, den, amp, val;
        idx_l = longint'(idx);
        h     = 64'sd1 <<< (LUT_AW - 1);
        amp   = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
        k     = (idx_l < h) ? idx_l : idx_l - h;
        num   = 64'sd16 * amp * k * (h - k);
        den   = 64'sd5 * h * h - 64'sd4 * k * (h - k);
        val   = (num + den / 64'sd2) / den;
        if (idx_l >= h) begin
            val = -val;
        end
        return val[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] sine_rom [2**LUT_AW];

    for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
        assign sine_rom[g] = sine_entry(g);
    end

    logic unused_hex;
    assign unused_hex = ^HEX_LINK;

    // -------------------------------------------------------------------------
    // Run-control FSM
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [7:0]         wrap_cnt_q, wrap_cnt_d;
    logic [15:0]        gap_cnt_q, gap_cnt_d;
    logic               done_q, done_d;

    // Configuration captured at start
    logic               sweep_q;
    logic               loop_q;
    logic [PHASE_W-1:0] f_start_q, f_inc_q, f_stop_q;
    logic [7:0]         burst_n_q;
    logic [15:0]        gap_q;

    logic               start_go;
    logic               launch;
    logic               launch_mute;
    logic [PHASE_W:0]   add_full;
    logic               carry;

    assign add_full = {1'b0, phase_q} + {1'b0, step_q};
    assign carry    = add_full[PHASE_W];

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        step_d      = step_q;
        wrap_cnt_d  = wrap_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        done_d      = 1'b0;
        start_go    = 1'b0;
        launch      = 1'b0;
        launch_mute = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    start_go   = 1'b1;
                    phase_d    = '0;
                    step_d     = (i_mode == 2'd1) ? i_f_start : i_step;
                    wrap_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = (i_mode == 2'd2) ? S_BURST_ON : S_RUN;
                end
            end

            S_RUN: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_sample_en) begin
                    launch  = 1'b1;
                    phase_d = add_full[PHASE_W-1:0];
                    if (sweep_q) begin
                        // Compare uses the step that produced this sample.
                        if (step_q >= f_stop_q) begin
                            if (loop_q) begin
                                step_d = f_start_q;
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            step_d = step_q + f_inc_q;
                        end
                    end
                end
            end

            S_BURST_ON: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_sample_en) begin
                    launch  = 1'b1;
                    phase_d = add_full[PHASE_W-1:0];
                    if (carry) begin
                        if (({1'b0, wrap_cnt_q} + 9'd1) == {1'b0, burst_n_q}) begin
                            wrap_cnt_d = '0;
                            if (gap_q == 16'd0) begin
                                phase_d = '0;
                            end else begin
                                gap_cnt_d = '0;
                                state_d   = S_BURST_OFF;
                            end
                        end else begin
                            wrap_cnt_d = wrap_cnt_q + 8'd1;
                        end
                    end
                end
            end

            S_BURST_OFF: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_sample_en) begin
                    // Muted sample: phase is held, shape forced to zero.
                    launch      = 1'b1;
                    launch_mute = 1'b1;
                    if (({1'b0, gap_cnt_q} + 17'd1) == {1'b0, gap_q}) begin
                        gap_cnt_d  = '0;
                        wrap_cnt_d = '0;
                        phase_d    = '0;
                        state_d    = S_BURST_ON;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            step_q     <= '0;
            wrap_cnt_q <= '0;
            gap_cnt_q  <= '0;
            done_q     <= 1'b0;
            sweep_q    <= 1'b0;
            loop_q     <= 1'b0;
            f_start_q  <= '0;
            f_inc_q    <= '0;
            f_stop_q   <= '0;
            burst_n_q  <= 8'd1;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            step_q     <= step_d;
            wrap_cnt_q <= wrap_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            done_q     <= done_d;
            if (start_go) begin
                sweep_q   <= (i_mode == 2'd1);
                loop_q    <= i_loop;
                f_start_q <= i_f_start;
                f_inc_q   <= i_f_inc;
                f_stop_q  <= i_f_stop;
                burst_n_q <= (i_burst_cycles == 8'd0) ? 8'd1 : i_burst_cycles;
                gap_q     <= i_gap_samples;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sample pipeline: phase capture -> shape/LUT -> gain/offset/saturate
    // -------------------------------------------------------------------------
    logic             s1_valid_q;
    logic             s1_mute_q;
    logic [WIDTH-1:0] s1_p_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_shape_q;
    logic [WIDTH-1:0] shape_d;
    logic [WIDTH-1:0] tri_u;
    logic [WIDTH-1:0] wave_q;
    logic             valid_q;
    logic             clip_q;

    always_comb begin
        tri_u = s1_p_q[WIDTH-1] ? ~{s1_p_q[WIDTH-2:0], 1'b0} : {s1_p_q[WIDTH-2:0], 1'b0};
        shape_d = '0;
        if (!s1_mute_q) begin
            case (i_sel_wave)
                3'd0:    shape_d = sine_rom[s1_p_q[WIDTH-1 -: LUT_AW]];
                3'd1:    shape_d = (s1_p_q[WIDTH-1 -: 8] < i_duty) ? SQ_HIGH : SQ_LOW;
                3'd2:    shape_d = {~tri_u[WIDTH-1], tri_u[WIDTH-2:0]};
                3'd3:    shape_d = {~s1_p_q[WIDTH-1], s1_p_q[WIDTH-2:0]};
                default: shape_d = '0;
            endcase
        end
    end

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;
    logic signed [PW:0]   sum;
    logic [WIDTH-1:0]     sat_d;
    logic                 clip_d;

    always_comb begin
        prod   = $signed({{(PW - WIDTH){s2_shape_q[WIDTH-1]}}, s2_shape_q})
               * $signed({{(PW - GAIN_W){1'b0}}, i_gain});
        // Arithmetic shift gives floor division by 2^(GAIN_W-1).
        scaled = prod >>> (GAIN_W - 1);
        sum    = {scaled[PW-1], scaled} + {{(PW + 1 - WIDTH){i_offset[WIDTH-1]}}, i_offset};
        sat_d  = sum[WIDTH-1:0];
        clip_d = 1'b0;
        if (sum > SAT_MAX) begin
            sat_d  = SAT_MAX[WIDTH-1:0];
            clip_d = 1'b1;
        end else if (sum < SAT_MIN) begin
            sat_d  = SAT_MIN[WIDTH-1:0];
            clip_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_mute_q  <= 1'b0;
            s1_p_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_shape_q <= '0;
            valid_q    <= 1'b0;
            wave_q     <= '0;
            clip_q     <= 1'b0;
        end else begin
            s1_valid_q <= launch;
            if (launch) begin
                s1_p_q    <= phase_q[PHASE_W-1 -: WIDTH];
                s1_mute_q <= launch_mute;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_shape_q <= shape_d;
            end
            valid_q <= s2_valid_q;
            clip_q  <= s2_valid_q & clip_d;
            if (s2_valid_q) begin
                wave_q <= sat_d;
            end
        end
    end

    assign o_wave      = wave_q;
    assign o_valid     = valid_q;
    assign o_clip      = clip_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_wave_gen_burst_sweep.sv
// -----------------------------------------------------------------------------
// Testbench for wave_gen_burst_sweep (WIDTH=24, PHASE_W=32, GAIN_W=8).
// Directed vectors with hand-computed expected samples. The driver pushes the
// expected {clip, wave} and the cycle it must appear on into queues; a monitor
// on the falling edge pops and compares whenever o_valid is high.
// -----------------------------------------------------------------------------
module tb_wave_gen_burst_sweep;
  localparam int W  = 24;
  localparam int PW = 32;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_sample_en = 1'b0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic [1:0]    i_mode = '0;
  logic          i_loop = 1'b0;
  logic [PW-1:0] i_step = '0;
  logic [PW-1:0] i_f_start = '0;
  logic [PW-1:0] i_f_inc = '0;
  logic [PW-1:0] i_f_stop = '0;
  logic [7:0]    i_burst_cycles = '0;
  logic [15:0]   i_gap_samples = '0;
  logic [2:0]    i_sel_wave = '0;
  logic [7:0]    i_duty = '0;
  logic [GW-1:0] i_gain = 8'd128;
  logic [W-1:0]  i_offset = '0;
  logic [W-1:0]  o_wave;
  logic          o_valid;
  logic          o_clip;
  logic          o_busy;
  logic          o_done;
  logic [1:0]    o_dbg_state;

  wave_gen_burst_sweep #(
    .WIDTH(W), .PHASE_W(PW), .LUT_AW(10), .GAIN_W(GW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sample_en(i_sample_en),
    .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode), .i_loop(i_loop),
    .i_step(i_step), .i_f_start(i_f_start), .i_f_inc(i_f_inc), .i_f_stop(i_f_stop),
    .i_burst_cycles(i_burst_cycles), .i_gap_samples(i_gap_samples),
    .i_sel_wave(i_sel_wave), .i_duty(i_duty), .i_gain(i_gain), .i_offset(i_offset),
    .o_wave(o_wave), .o_valid(o_valid), .o_clip(o_clip), .o_busy(o_busy),
    .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  int         t_q[$];
  int         compared = 0;
  int         mismatched = 0;
  int         done_cnt = 0;
  logic [W:0] mon_e;
  int         mon_t;

  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_valid) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_valid: o_wave=%0d clip=%0b at cycle %0d, required no sample",
                 $signed(o_wave), o_clip, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = t_q.pop_front();
        if ({o_clip, o_wave} !== mon_e || cyc != mon_t) begin
          mismatched++;
          $display("FAIL sample: got wave=%0d clip=%0b cycle=%0d, required wave=%0d clip=%0b cycle=%0d",
                   $signed(o_wave), o_clip, cyc, $signed(mon_e[W-1:0]), mon_e[W], mon_t);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic strobe(input int v, input bit c);
    logic [W:0] e;
    e = {c, v[W-1:0]};
    i_sample_en = 1'b1;
    exp_q.push_back(e);
    t_q.push_back(cyc + 3);
    tick();
    i_sample_en = 1'b0;
  endtask

  task automatic strobe_none();
    i_sample_en = 1'b1;
    tick();
    i_sample_en = 1'b0;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic stop_pulse();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- expected tables ----------------
  int tri_exp[16] = '{-8388608, -6291456, -4194304, -2097152, 0, 2097152, 4194304, 6291456,
                      8388607, 6291455, 4194303, 2097151, -1, -2097153, -4194305, -6291457};
  int clip_exp[16] = '{-8388608, -8388608, -8339456, -6250496, -4161536, -2072576, 16384, 2105344,
                       4194304, 6283264, 8372224, 8388607, 8388607, 8388607, 8388607, 8388607};
  bit clip_flag[16] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int burst_on[4] = '{-8388508, -4194204, 100, 4194404};
  int sweep_units[5] = '{0, 1, 3, 4, 6};

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    #2 rst = 1'b1;
    #1;
    check("reset_valid", o_valid, 0);
    check("reset_wave", o_wave, 0);
    check("reset_busy", o_busy, 0);
    check("reset_clip", o_clip, 0);
    check("reset_done", o_done, 0);
    check("reset_state", o_dbg_state, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Sawtooth, continuous, step 2^28
    i_mode = 2'd0; i_sel_wave = 3'd3; i_step = 32'h1000_0000;
    start_pulse();
    check("busy_after_start", o_busy, 1);
    for (int k = 0; k < 16; k++) strobe(-8388608 + k * 1048576, 1'b0);
    stop_pulse();
    check("busy_after_stop", o_busy, 0);
    drain("drain_saw");

    // Square, duty 64/256
    i_sel_wave = 3'd1; i_duty = 8'd64;
    start_pulse();
    for (int k = 0; k < 16; k++) strobe((k < 4) ? 8388607 : -8388607, 1'b0);
    stop_pulse();
    drain("drain_square");

    // Triangle
    i_sel_wave = 3'd2;
    start_pulse();
    for (int k = 0; k < 16; k++) strobe(tri_exp[k], 1'b0);
    stop_pulse();
    drain("drain_triangle");

    // Sine at quarter-wave points
    i_sel_wave = 3'd0; i_step = 32'h4000_0000;
    start_pulse();
    strobe(0, 1'b0);
    strobe(8388607, 1'b0);
    strobe(0, 1'b0);
    strobe(-8388607, 1'b0);
    stop_pulse();
    drain("drain_sine");

    // Sawtooth with gain 255 and offset 0x400000: saturation both ways
    i_sel_wave = 3'd3; i_step = 32'h1000_0000; i_gain = 8'd255; i_offset = 24'h400000;
    start_pulse();
    for (int k = 0; k < 16; k++) strobe(clip_exp[k], clip_flag[k]);
    stop_pulse();
    drain("drain_clip");
    i_gain = 8'd128;

    // DC with negative offset
    i_sel_wave = 3'd4; i_offset = -24'sd5;
    start_pulse();
    strobe(-5, 1'b0);
    strobe(-5, 1'b0);
    stop_pulse();
    drain("drain_dc");
    i_offset = '0;

    // Sweep, non-looping
    i_sel_wave = 3'd3; i_mode = 2'd1; i_loop = 1'b0;
    i_f_start = 32'h0400_0000; i_f_inc = 32'h0400_0000; i_f_stop = 32'h1000_0000;
    start_pulse();
    strobe(-8388608, 1'b0);
    strobe(-8388608 + 1 * 262144, 1'b0);
    strobe(-8388608 + 3 * 262144, 1'b0);
    strobe(-8388608 + 6 * 262144, 1'b0);
    check("sweep_done_pulse", o_done, 1);
    check("sweep_busy_falls", o_busy, 0);
    strobe_none(); strobe_none(); strobe_none();
    drain("drain_sweep");
    check("sweep_done_count", done_cnt, 1);

    // Sweep, looping: step returns to f_start after reaching f_stop
    i_loop = 1'b1; i_f_stop = 32'h0800_0000;
    start_pulse();
    for (int k = 0; k < 5; k++) strobe(-8388608 + sweep_units[k] * 262144, 1'b0);
    check("sweep_loop_busy", o_busy, 1);
    stop_pulse();
    drain("drain_sweep_loop");
    check("sweep_loop_no_done", done_cnt, 1);

    // Burst N=2, gap=3, irregular strobe spacing
    i_mode = 2'd2; i_step = 32'h4000_0000; i_burst_cycles = 8'd2; i_gap_samples = 16'd3;
    i_offset = 24'd100;
    start_pulse();
    check("burst_state_on", o_dbg_state, 2);
    for (int k = 0; k < 15; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (k < 8) strobe(burst_on[k % 4], 1'b0);
      else if (k < 11) strobe(100, 1'b0);
      else strobe(burst_on[k - 11], 1'b0);
    end
    stop_pulse();
    drain("drain_burst");
    i_offset = '0;

    // Start and stop together: stays idle
    i_mode = 2'd0; i_step = 32'h1000_0000;
    i_start = 1'b1; i_stop = 1'b1;
    tick();
    i_start = 1'b0; i_stop = 1'b0;
    check("start_stop_idle", o_busy, 0);
    strobe_none(); strobe_none();
    drain("drain_start_stop");

    // Reset mid-run: outputs clear at once, in-flight samples are lost
    start_pulse();
    for (int k = 0; k < 5; k++) strobe(-8388608 + k * 1048576, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_wave", o_wave, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_clip", o_clip, 0);
    check("midrst_done", o_done, 0);
    exp_q.delete();
    t_q.delete();
    tick(); tick();
    rst = 1'b0;
    strobe_none(); strobe_none(); strobe_none();
    repeat (8) tick();
    check("midrst_busy_after", o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
